// File: rtl/frog_button_conditioner_pkg.sv
// Shared constants and per-channel state encoding for the frogger button input stage.
// Channel indices double as bit positions in btn_level and the internal strobe vectors.
package frog_pkg;

    localparam int unsigned BTN_UP  = 0;
    localparam int unsigned BTN_DN  = 1;
    localparam int unsigned BTN_LT  = 2;
    localparam int unsigned BTN_RT  = 3;
    localparam int unsigned NUM_BTN = 4;

    // Default timing for a 100 MHz clock
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_EN       = 1;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 25_000_000;

    typedef enum logic [2:0] {
        CH_IDLE     = 3'd0,
        CH_FIRST    = 3'd1,
        CH_HELD_DLY = 3'd2,
        CH_HELD_RPT = 3'd3,
        CH_WAIT_REL = 3'd4
    } ch_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frog_button_conditioner_if.sv
// Raw button pins and conditioned move strobes between the board and the game logic.
// slave is the conditioner side; master is whatever drives the pins and consumes the strobes.
interface frog_button_conditioner_if;

    logic       btn_up_raw;
    logic       btn_dn_raw;
    logic       btn_lt_raw;
    logic       btn_rt_raw;
    logic       up_n;
    logic       down_n;
    logic       left_n;
    logic       right_n;
    logic [3:0] btn_level;

    modport master (
        output btn_up_raw, btn_dn_raw, btn_lt_raw, btn_rt_raw,
        input  up_n, down_n, left_n, right_n, btn_level
    );

    modport slave (
        input  btn_up_raw, btn_dn_raw, btn_lt_raw, btn_rt_raw,
        output up_n, down_n, left_n, right_n, btn_level
    );

endinterface

// File: rtl/frog_button_conditioner_btn_debounce_channel.sv
// One button: two-flop synchroniser, stable-count debounce, and a press/auto-repeat FSM
// producing a one-cycle strobe request per move event.
module btn_debounce_channel
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_n,
    output logic level,
    output logic strobe_req
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pressed_sync;

    ch_state_e        state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             strobe_q;

    always_comb begin
        sync1_d      = btn_raw_n;
        sync2_d      = sync1_q;
        pressed_sync = ~sync2_q;
        level_d      = level_q;
        db_cnt_d     = '0;
        // Any cycle agreeing with the accepted level restarts the stability count
        if (pressed_sync != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = pressed_sync;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // rpt_cnt_q counts edges since the last strobe; release overrides any pending strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CH_IDLE;
            rpt_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            rpt_cnt_q <= (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + RPT_W'(1);
            if (!level_q) begin
                state_q   <= CH_IDLE;
                rpt_cnt_q <= '0;
            end else begin
                case (state_q)
                    CH_IDLE: begin
                        state_q   <= CH_FIRST;
                        strobe_q  <= 1'b1;
                        rpt_cnt_q <= '0;
                    end
                    CH_FIRST: begin
                        state_q <= (REPEAT_EN != 0) ? CH_HELD_DLY : CH_WAIT_REL;
                    end
                    CH_HELD_DLY: begin
                        if (rpt_cnt_q == DLY_LAST) begin
                            state_q   <= CH_HELD_RPT;
                            strobe_q  <= 1'b1;
                            rpt_cnt_q <= '0;
                        end
                    end
                    CH_HELD_RPT: begin
                        if (rpt_cnt_q == RATE_LAST) begin
                            strobe_q  <= 1'b1;
                            rpt_cnt_q <= '0;
                        end
                    end
                    CH_WAIT_REL: begin
                        state_q <= CH_WAIT_REL;
                    end
                    default: begin
                        state_q <= CH_IDLE;
                    end
                endcase
            end
        end
    end

    assign level      = level_q;
    assign strobe_req = strobe_q;

endmodule

// File: rtl/frog_button_conditioner.sv
// Four debounced direction channels feeding registered active-low move strobes.
// Simultaneous opposing requests (up/down, left/right) cancel each other for that cycle.
module frog_button_conditioner
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic                      clk,
    input  logic                      reset,
    frog_button_conditioner_if.slave  btn_if
);

    logic [NUM_BTN-1:0] raw_n;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] strobe_n_q, strobe_n_d;
    logic [NUM_BTN-1:0] btn_level_q, btn_level_d;

    assign raw_n[BTN_UP] = btn_if.btn_up_raw;
    assign raw_n[BTN_DN] = btn_if.btn_dn_raw;
    assign raw_n[BTN_LT] = btn_if.btn_lt_raw;
    assign raw_n[BTN_RT] = btn_if.btn_rt_raw;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_raw_n  (raw_n[g]),
            .level      (level[g]),
            .strobe_req (req[g])
        );
    end

    // Cancelled strobes are simply lost; the channel FSMs keep their own schedule
    always_comb begin
        strobe_n_d         = '1;
        strobe_n_d[BTN_UP] = ~(req[BTN_UP] & ~req[BTN_DN]);
        strobe_n_d[BTN_DN] = ~(req[BTN_DN] & ~req[BTN_UP]);
        strobe_n_d[BTN_LT] = ~(req[BTN_LT] & ~req[BTN_RT]);
        strobe_n_d[BTN_RT] = ~(req[BTN_RT] & ~req[BTN_LT]);
        btn_level_d        = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_n_q  <= '1;
            btn_level_q <= '0;
        end else begin
            strobe_n_q  <= strobe_n_d;
            btn_level_q <= btn_level_d;
        end
    end

    assign btn_if.up_n      = strobe_n_q[BTN_UP];
    assign btn_if.down_n    = strobe_n_q[BTN_DN];
    assign btn_if.left_n    = strobe_n_q[BTN_LT];
    assign btn_if.right_n   = strobe_n_q[BTN_RT];
    assign btn_if.btn_level = btn_level_q;

endmodule

// File: tb/tb_frog_button_conditioner.sv
// Directed bench: two conditioners (repeat off / repeat on) share the same raw pins;
// each step lists the edge-by-edge strobe and level values expected for one scenario.
module tb_frog_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic up_raw, dn_raw, lt_raw, rt_raw;
    int   checks = 0;
    int   errors = 0;
    int   e = 0;

    logic [3:0] nr_strb, r_strb, nr_lvl, r_lvl;

    frog_button_conditioner_if if_nr ();
    frog_button_conditioner_if if_r ();

    assign if_nr.btn_up_raw = up_raw;
    assign if_nr.btn_dn_raw = dn_raw;
    assign if_nr.btn_lt_raw = lt_raw;
    assign if_nr.btn_rt_raw = rt_raw;
    assign if_r.btn_up_raw  = up_raw;
    assign if_r.btn_dn_raw  = dn_raw;
    assign if_r.btn_lt_raw  = lt_raw;
    assign if_r.btn_rt_raw  = rt_raw;

    assign nr_strb = {if_nr.right_n, if_nr.left_n, if_nr.down_n, if_nr.up_n};
    assign r_strb  = {if_r.right_n, if_r.left_n, if_r.down_n, if_r.up_n};
    assign nr_lvl  = if_nr.btn_level;
    assign r_lvl   = if_r.btn_level;

    frog_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (5)
    ) dut_nr (
        .clk    (clk),
        .reset  (reset),
        .btn_if (if_nr)
    );

    frog_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (5)
    ) dut_r (
        .clk    (clk),
        .reset  (reset),
        .btn_if (if_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic settle();
        up_raw = 1'b1;
        dn_raw = 1'b1;
        lt_raw = 1'b1;
        rt_raw = 1'b1;
        reset  = 1'b0;
        for (int unsigned i = 0; i < 15; i++) tick();
        chk("settle_nr_strb", nr_strb, 4'b1111);
        chk("settle_r_strb", r_strb, 4'b1111);
        chk("settle_nr_lvl", nr_lvl, 4'b0000);
        chk("settle_r_lvl", r_lvl, 4'b0000);
    endtask

    initial begin
        up_raw = 1'b1;
        dn_raw = 1'b1;
        lt_raw = 1'b1;
        rt_raw = 1'b1;
        reset  = 1'b1;
        tick();
        tick();
        chk("reset_nr_strb", nr_strb, 4'b1111);
        chk("reset_r_strb", r_strb, 4'b1111);
        chk("reset_nr_lvl", nr_lvl, 4'b0000);
        chk("reset_r_lvl", r_lvl, 4'b0000);
        settle();

        // Clean up press, no repeat: strobe after edge 7 only, level from edge 6
        up_raw = 1'b0;
        e = -1;
        for (int unsigned i = 0; i < 30; i++) begin
            tick();
            chk("clean_strb", nr_strb, (e == 7) ? 4'b1110 : 4'b1111);
            chk("clean_lvl", nr_lvl, (e >= 6) ? 4'b0001 : 4'b0000);
        end
        settle();

        // Left bounces in 2-cycle runs for 12 edges, then stays low from edge 12
        e = -1;
        for (int unsigned i = 0; i < 30; i++) begin
            lt_raw = (i < 12 && (i % 4) >= 2) ? 1'b1 : 1'b0;
            tick();
            chk("bounce_strb", nr_strb, (e == 19) ? 4'b1011 : 4'b1111);
            chk("bounce_lvl", nr_lvl, (e >= 18) ? 4'b0100 : 4'b0000);
        end
        settle();

        // Right held edges 0..39: first strobe, delayed repeat, periodic repeats, clean release
        e = -1;
        for (int unsigned i = 0; i < 56; i++) begin
            rt_raw = (i < 40) ? 1'b0 : 1'b1;
            tick();
            chk("repeat_strb",
                r_strb,
                (e == 7 || (e >= 17 && e <= 42 && ((e - 17) % 5) == 0)) ? 4'b0111 : 4'b1111);
            chk("repeat_lvl", r_lvl, (e >= 6 && e < 46) ? 4'b1000 : 4'b0000);
            chk("norepeat_strb", nr_strb, (e == 7) ? 4'b0111 : 4'b1111);
        end
        settle();

        // Up and down together cancel, including their repeats
        up_raw = 1'b0;
        dn_raw = 1'b0;
        e = -1;
        for (int unsigned i = 0; i < 25; i++) begin
            tick();
            chk("conflict_ud_strb", r_strb, 4'b1111);
            chk("conflict_ud_lvl", r_lvl, (e >= 6) ? 4'b0011 : 4'b0000);
        end
        settle();

        // Up and left are orthogonal and strobe together
        up_raw = 1'b0;
        lt_raw = 1'b0;
        e = -1;
        for (int unsigned i = 0; i < 16; i++) begin
            tick();
            chk("ortho_strb", r_strb, (e == 7) ? 4'b1010 : 4'b1111);
            chk("ortho_lvl", r_lvl, (e >= 6) ? 4'b0101 : 4'b0000);
        end
        settle();

        // Down held across a one-edge reset at edge 20: re-pressed, strobes at 28 and 38
        dn_raw = 1'b0;
        e = -1;
        for (int unsigned i = 0; i < 40; i++) begin
            reset = (i == 20) ? 1'b1 : 1'b0;
            tick();
            chk("rst_hold_strb",
                r_strb,
                (e == 7 || e == 17 || e == 28 || e == 38) ? 4'b1101 : 4'b1111);
            chk("rst_hold_lvl", r_lvl, ((e >= 6 && e < 20) || e >= 27) ? 4'b0010 : 4'b0000);
        end
        settle();

        // Three-cycle glitch never reaches the debounce threshold
        e = -1;
        for (int unsigned i = 0; i < 20; i++) begin
            up_raw = (i < 3) ? 1'b0 : 1'b1;
            tick();
            chk("glitch_nr_strb", nr_strb, 4'b1111);
            chk("glitch_r_strb", r_strb, 4'b1111);
            chk("glitch_nr_lvl", nr_lvl, 4'b0000);
            chk("glitch_r_lvl", r_lvl, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
